// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single-port,
// zero-delay RAM. One access per cycle goes to requester A or B. A requester may
// lock the grant for up to MAX_BURST consecutive beats while the other waits.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   a_valid/a_ready              A handshake (ready is combinational on valids/state)
//   a_write, a_lock              A command: 1 = write; keep grant for next beat
//   a_address, a_wdata           A address and write data
//   a_rvalid, a_rdata            A registered read data, rvalid is a one-cycle pulse
//   b_*                          same set for requester B
//   ram_write, ram_address       to ram.write / ram.address
//   ram_data                     to ram.data; driven only while ram_write = 1
module ram_arbiter #(
  parameter int unsigned ADDRESS_BITS = 1,
  parameter int unsigned DATA_BITS    = 1,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic                    a_write,
  input  logic                    a_lock,
  input  logic [ADDRESS_BITS-1:0] a_address,
  input  logic [DATA_BITS-1:0]    a_wdata,
  output logic                    a_rvalid,
  output logic [DATA_BITS-1:0]    a_rdata,

  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic                    b_write,
  input  logic                    b_lock,
  input  logic [ADDRESS_BITS-1:0] b_address,
  input  logic [DATA_BITS-1:0]    b_wdata,
  output logic                    b_rvalid,
  output logic [DATA_BITS-1:0]    b_rdata,

  output logic                    ram_write,
  output logic [ADDRESS_BITS-1:0] ram_address,
  inout  wire  [DATA_BITS-1:0]    ram_data
);

  localparam int unsigned BurstBits = $clog2(MAX_BURST + 1);
  localparam logic [BurstBits-1:0] MaxCount = BurstBits'(MAX_BURST);

  typedef enum logic [1:0] {OwnNone, OwnA, OwnB} owner_e;

  owner_e                owner_q, owner_d;
  logic [BurstBits-1:0]  burst_q, burst_d;
  logic                  prio_b_q, prio_b_d;   // 1: B wins a tie
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_BITS-1:0]  a_rdata_q, b_rdata_q;

  logic                  grant_a, grant_b;
  logic                  a_hold, b_hold;
  logic [BurstBits-1:0]  burst_inc;
  logic [DATA_BITS-1:0]  wdata_sel;

  // Grant selection
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    a_hold  = (owner_q == OwnA) && a_valid && ((burst_q < MaxCount) || !b_valid);
    b_hold  = (owner_q == OwnB) && b_valid && ((burst_q < MaxCount) || !a_valid);
    if (!reset) begin
      if (a_hold) begin
        grant_a = 1'b1;
      end else if (b_hold) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        // A passed-over owner loses here since prio already points away from it.
        grant_a = !prio_b_q;
        grant_b = prio_b_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // Saturate so a long uncontested burst cannot wrap and re-open the hold window.
  assign burst_inc = (burst_q == MaxCount) ? burst_q : burst_q + BurstBits'(1);

  // Ownership / priority next state
  always_comb begin
    owner_d  = OwnNone;
    burst_d  = '0;
    prio_b_d = prio_b_q;
    if (grant_a) begin
      prio_b_d = 1'b1;
      if (a_lock) begin
        owner_d = OwnA;
        burst_d = (owner_q == OwnA) ? burst_inc : BurstBits'(1);
      end
    end else if (grant_b) begin
      prio_b_d = 1'b0;
      if (b_lock) begin
        owner_d = OwnB;
        burst_d = (owner_q == OwnB) ? burst_inc : BurstBits'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= OwnNone;
      burst_q    <= '0;
      prio_b_q   <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      prio_b_q   <= prio_b_d;
      a_rvalid_q <= grant_a && !a_write;
      b_rvalid_q <= grant_b && !b_write;
      if (grant_a && !a_write) a_rdata_q <= ram_data;
      if (grant_b && !b_write) b_rdata_q <= ram_data;
    end
  end

  // RAM drive
  always_comb begin
    ram_write   = 1'b0;
    ram_address = '0;
    wdata_sel   = '0;
    if (grant_a) begin
      ram_write   = a_write;
      ram_address = a_address;
      wdata_sel   = a_wdata;
    end else if (grant_b) begin
      ram_write   = b_write;
      ram_address = b_address;
      wdata_sel   = b_wdata;
    end
  end

  assign ram_data = ram_write ? wdata_sel : {DATA_BITS{1'bz}};

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and constrained-random bench for ram_arbiter with a behavioural RAM
// (zero-delay read, write at the clock edge, contents reloaded on reset).
module tb_ram_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_write, a_lock, a_ready, a_rvalid;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_write, b_lock, b_ready, b_rvalid;
  logic [AW-1:0] b_address;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          ram_write;
  logic [AW-1:0] ram_address;
  wire  [DW-1:0] ram_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem    [16];
  logic [DW-1:0] shadow [16];

  ram_arbiter #(
    .ADDRESS_BITS(AW),
    .DATA_BITS   (DW),
    .MAX_BURST   (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_write    (a_write),
    .a_lock     (a_lock),
    .a_address  (a_address),
    .a_wdata    (a_wdata),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_write    (b_write),
    .b_lock     (b_lock),
    .b_address  (b_address),
    .b_wdata    (b_wdata),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .ram_write  (ram_write),
    .ram_address(ram_address),
    .ram_data   (ram_data)
  );

  always #5 clock = ~clock;

  // Behavioural RAM
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
    end else if (ram_write) begin
      mem[ram_address] <= ram_data;
    end
  end
  assign ram_data = ram_write ? {DW{1'bz}} : mem[ram_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic init_shadow;
    for (int i = 0; i < 16; i++) shadow[i] = 8'hA0 + 8'(i);
  endtask

  int            cnt_a, cnt_b;
  logic          exp_b;
  logic [1:0]    prev_grant;
  int            g;
  logic          tb_prio_b;
  logic [1:0]    prev_rv;
  logic [DW-1:0] prev_rd;
  logic          gw;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwd;

  initial begin
    reset = 1'b1;
    a_valid = 1'b1; a_write = 1'b0; a_lock = 1'b0; a_address = '0; a_wdata = '0;
    b_valid = 1'b1; b_write = 1'b0; b_lock = 1'b0; b_address = '0; b_wdata = '0;
    init_shadow();

    // Reset values, both requesters valid
    next_cycle();
    #1;
    check("rst_ready", {a_ready, b_ready}, 2'b00);
    check("rst_ram_write", ram_write, 1'b0);
    check("rst_ram_data_undriven", ram_data, shadow[0]);
    check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("rst_a_rdata", a_rdata, 8'h00);
    check("rst_b_rdata", b_rdata, 8'h00);
    next_cycle();
    reset = 1'b0;
    #1;
    check("post_rst_ready", {a_ready, b_ready}, 2'b10);
    check("post_rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("first_read_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    check("first_read_rdata", a_rdata, shadow[0]);

    // Single-side write then read of address 3
    a_valid = 1'b1; a_write = 1'b1; a_address = 4'd3; a_wdata = 8'h5A;
    #1;
    check("wr_ready", {a_ready, b_ready}, 2'b10);
    check("wr_ram_write", ram_write, 1'b1);
    check("wr_ram_address", ram_address, 4'd3);
    check("wr_ram_data", ram_data, 8'h5A);
    next_cycle();
    shadow[3] = 8'h5A;
    a_write = 1'b0;
    #1;
    check("rd_ready", {a_ready, b_ready}, 2'b10);
    check("rd_ram_write", ram_write, 1'b0);
    check("rd_ram_data", ram_data, 8'h5A);
    next_cycle();
    a_valid = 1'b0;
    #1;
    check("raw_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    check("raw_rdata", a_rdata, 8'h5A);
    next_cycle();
    #1;
    check("raw_rvalid_pulse", {a_rvalid, b_rvalid}, 2'b00);
    check("raw_rdata_hold", a_rdata, 8'h5A);

    // Round-robin: prio points at B after A's last beat
    a_valid = 1'b1; a_address = 4'd1; b_valid = 1'b1; b_write = 1'b0; b_address = 4'd2;
    cnt_a = 0; cnt_b = 0; exp_b = 1'b1; prev_grant = 2'b00;
    #1;
    for (int i = 0; i < 100; i++) begin
      check("rr_grant", {a_ready, b_ready}, exp_b ? 2'b01 : 2'b10);
      if (i > 0) check("rr_rvalid_route", {a_rvalid, b_rvalid}, prev_grant);
      if (a_ready) cnt_a++;
      if (b_ready) cnt_b++;
      prev_grant = exp_b ? 2'b01 : 2'b10;
      exp_b = !exp_b;
      next_cycle();
      #1;
    end
    check("rr_count_a", cnt_a, 50);
    check("rr_count_b", cnt_b, 50);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("rr_last_rvalid", {a_rvalid, b_rvalid}, 2'b10);

    // Burst bound, MAX_BURST = 4
    a_valid = 1'b1; a_lock = 1'b1; a_address = 4'd4;
    #1;
    check("burst_beat1", {a_ready, b_ready}, 2'b10);
    next_cycle();
    b_valid = 1'b1;
    #1;
    check("burst_beat2", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("burst_beat3", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("burst_beat4", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("burst_forced_b", {a_ready, b_ready}, 2'b01);
    next_cycle();
    #1;
    check("burst_a_resume", {a_ready, b_ready}, 2'b10);
    next_cycle();
    b_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("burst_uncontested", {a_ready, b_ready}, 2'b10);
      next_cycle();
    end
    a_valid = 1'b0; a_lock = 1'b0;
    next_cycle();

    // Reset during A's third locked beat, B waiting
    a_valid = 1'b1; a_lock = 1'b1; a_write = 1'b1; a_address = 4'd5; a_wdata = 8'h11;
    #1;
    check("mid_beat1", {a_ready, b_ready}, 2'b10);
    next_cycle();
    a_wdata = 8'h22;
    #1;
    check("mid_beat2", {a_ready, b_ready}, 2'b10);
    next_cycle();
    reset = 1'b1; b_valid = 1'b1; b_address = 4'd7; a_write = 1'b0; a_address = 4'd6;
    #1;
    check("mid_reset_ready", {a_ready, b_ready}, 2'b00);
    check("mid_reset_ram_write", ram_write, 1'b0);
    next_cycle();
    reset = 1'b0;
    init_shadow();
    #1;
    check("mid_no_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("mid_r1", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("mid_r2", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("mid_r3", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("mid_r4", {a_ready, b_ready}, 2'b10);
    next_cycle();
    #1;
    check("mid_b_granted", {a_ready, b_ready}, 2'b01);
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0;
    next_cycle();

    // Random mix, no locks; prio points at A after B's beat
    tb_prio_b = 1'b0;
    prev_rv = 2'b00;
    prev_rd = '0;
    for (int i = 0; i < 300; i++) begin
      a_valid = 1'($urandom_range(0, 1)); a_write = 1'($urandom_range(0, 1));
      a_address = 4'($urandom_range(0, 15)); a_wdata = 8'($urandom_range(0, 255));
      b_valid = 1'($urandom_range(0, 1)); b_write = 1'($urandom_range(0, 1));
      b_address = 4'($urandom_range(0, 15)); b_wdata = 8'($urandom_range(0, 255));
      #1;
      if (a_valid && b_valid) g = tb_prio_b ? 2 : 1;
      else if (a_valid)       g = 1;
      else if (b_valid)       g = 2;
      else                    g = 0;
      check("rnd_ready", {a_ready, b_ready}, {g == 1, g == 2});
      check("rnd_rvalid", {a_rvalid, b_rvalid}, prev_rv);
      if (prev_rv[1]) check("rnd_a_rdata", a_rdata, prev_rd);
      if (prev_rv[0]) check("rnd_b_rdata", b_rdata, prev_rd);
      gw    = (g == 1) ? a_write : (g == 2) ? b_write : 1'b0;
      gaddr = (g == 1) ? a_address : (g == 2) ? b_address : 4'd0;
      gwd   = (g == 1) ? a_wdata : b_wdata;
      check("rnd_ram_write", ram_write, gw);
      check("rnd_ram_address", ram_address, gaddr);
      check("rnd_ram_data", ram_data, gw ? gwd : shadow[gaddr]);
      prev_rv = 2'b00;
      if (g != 0) begin
        tb_prio_b = (g == 1);
        if (gw) begin
          shadow[gaddr] = gwd;
        end else begin
          prev_rv = (g == 1) ? 2'b10 : 2'b01;
          prev_rd = shadow[gaddr];
        end
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
